// File: rtl/program_sequencer.sv
// Instruction-address sequencer: registered PC with sequential fetch, absolute jump,
// signed relative branch and a LIFO call/return stack with sticky fault flags.
module program_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int OFF_W       = 8,
  parameter int STACK_DEPTH = 8,
  parameter int RESET_ADDR  = 0,
  parameter int STEP        = 1,
  localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CE,
  input  logic              load,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] IN,
  input  logic [OFF_W-1:0]  OFFSET,
  output logic [ADDR_W-1:0] OUT,
  output logic [DEPTH_W-1:0] depth,
  output logic              ovf,
  output logic              unf
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [ADDR_W-1:0]  RESET_V = ADDR_W'(RESET_ADDR);
  localparam logic [ADDR_W-1:0]  STEP_V  = ADDR_W'(STEP);
  localparam logic [DEPTH_W-1:0] FULL_V  = DEPTH_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_NEXT   = 3'b000,
    OP_JUMP   = 3'b001,
    OP_BRANCH = 3'b010,
    OP_CALL   = 3'b011,
    OP_RET    = 3'b100
  } op_e;

  logic [ADDR_W-1:0]  r_pc;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_ovf;
  logic               r_unf;

  logic [ADDR_W-1:0]  w_pc_next;
  logic [DEPTH_W-1:0] w_depth_next;
  logic               w_ovf_next;
  logic               w_unf_next;
  logic               w_push;
  logic [ADDR_W-1:0]  w_ret_addr;
  logic [ADDR_W-1:0]  w_branch_addr;
  logic [ADDR_W-1:0]  w_top;
  logic [IDX_W-1:0]   w_push_idx;
  logic [IDX_W-1:0]   w_top_idx;
  logic               w_empty;
  logic               w_full;
  logic [ADDR_W-1:0]  w_stack [STACK_DEPTH];

  assign w_empty       = (r_depth == '0);
  assign w_full        = (r_depth == FULL_V);
  assign w_ret_addr    = r_pc + STEP_V;
  assign w_branch_addr = r_pc + ADDR_W'($signed(OFFSET));
  assign w_push_idx    = IDX_W'(r_depth);
  // Clamp the pop index when empty so the read never leaves the array bounds.
  assign w_top_idx     = w_empty ? '0 : IDX_W'(r_depth - 1'b1);
  assign w_top         = w_stack[w_top_idx];

  always_comb begin
    w_pc_next    = r_pc;
    w_depth_next = r_depth;
    w_ovf_next   = r_ovf;
    w_unf_next   = r_unf;
    w_push       = 1'b0;
    if (load) begin
      w_pc_next = IN;
    end else begin
      case (op)
        OP_NEXT:   w_pc_next = w_ret_addr;
        OP_JUMP:   w_pc_next = IN;
        OP_BRANCH: w_pc_next = w_branch_addr;
        OP_CALL: begin
          if (w_full) begin
            w_ovf_next = 1'b1;
          end else begin
            w_push       = 1'b1;
            w_depth_next = r_depth + 1'b1;
            w_pc_next    = IN;
          end
        end
        OP_RET: begin
          if (w_empty) begin
            w_unf_next = 1'b1;
          end else begin
            w_depth_next = r_depth - 1'b1;
            w_pc_next    = w_top;
          end
        end
        default: w_pc_next = r_pc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc    <= RESET_V;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (CE) begin
      r_pc    <= w_pc_next;
      r_depth <= w_depth_next;
      r_ovf   <= w_ovf_next;
      r_unf   <= w_unf_next;
    end
  end

  // Stack entries carry no reset: contents are only meaningful below r_depth.
  genvar gi;
  generate
    for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
      logic [ADDR_W-1:0] r_entry;
      always_ff @(posedge clk) begin
        if (reset && CE && w_push && (w_push_idx == IDX_W'(gi))) begin
          r_entry <= w_ret_addr;
        end
      end
      assign w_stack[gi] = r_entry;
    end
  endgenerate

  assign OUT   = r_pc;
  assign depth = r_depth;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: directed scenarios plus random traffic
// compared every cycle against a queue-based behavioural model.
module tb_program_sequencer;

  localparam int ADDR_W = 16;
  localparam int OFF_W  = 8;
  localparam int DEPTH  = 8;
  localparam int MASK   = 32'h0000_FFFF;

  logic              clk = 1'b0;
  logic              reset;
  logic              CE;
  logic              load;
  logic [2:0]        op;
  logic [ADDR_W-1:0] IN;
  logic [OFF_W-1:0]  OFFSET;
  logic [ADDR_W-1:0] OUT;
  logic [3:0]        depth;
  logic              ovf;
  logic              unf;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_pc;
  int m_stack[$];
  int m_ovf;
  int m_unf;

  program_sequencer #(
    .ADDR_W(ADDR_W), .OFF_W(OFF_W), .STACK_DEPTH(DEPTH), .RESET_ADDR(0), .STEP(1)
  ) dut (
    .clk(clk), .reset(reset), .CE(CE), .load(load), .op(op), .IN(IN),
    .OFFSET(OFFSET), .OUT(OUT), .depth(depth), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit ce, input bit ld,
                            input int o, input int in_v, input int off_v);
    if (!r) begin
      m_pc = 0;
      m_stack.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (ce) begin
      if (ld) m_pc = in_v;
      else begin
        case (o)
          0: m_pc = (m_pc + 1) & MASK;
          1: m_pc = in_v;
          2: m_pc = (m_pc + off_v) & MASK;
          3: if (m_stack.size() < DEPTH) begin
               m_stack.push_back((m_pc + 1) & MASK);
               m_pc = in_v;
             end else m_ovf = 1;
          4: if (m_stack.size() > 0) m_pc = m_stack.pop_back();
             else m_unf = 1;
          default: ;
        endcase
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare all outputs.
  task automatic cyc(input bit r, input bit ce, input bit ld, input int o,
                     input int in_v, input int off_v);
    logic [7:0] off8;
    reset  = r;
    CE     = ce;
    load   = ld;
    op     = 3'(o);
    IN     = 16'(in_v);
    off8   = 8'(off_v);
    OFFSET = off8;
    @(posedge clk);
    model_step(r, ce, ld, o, in_v & MASK, int'($signed(off8)));
    #1;
    check_eq("out",   int'(OUT),   m_pc);
    check_eq("depth", int'(depth), m_stack.size());
    check_eq("ovf",   int'(ovf),   m_ovf);
    check_eq("unf",   int'(unf),   m_unf);
    $display("txn r=%0b ce=%0b ld=%0b op=%0d in=%04h off=%02h -> OUT=%04h depth=%0d ovf=%0b unf=%0b",
             r, ce, ld, o, in_v & MASK, off8, OUT, depth, ovf, unf);
  endtask

  initial begin
    int o, r_v, ce_v, ld_v;
    m_pc = 0; m_ovf = 0; m_unf = 0;

    // 1: reset then sequential fetch
    cyc(0, 1, 0, 0, 0, 0);
    check_eq("t1_reset_out", int'(OUT), 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0, 0);
    check_eq("t1_out5", int'(OUT), 5);

    // 2: wrap on NEXT and backwards branch
    cyc(1, 1, 1, 0, 'hFFFF, 0);
    cyc(1, 1, 0, 0, 0, 0);
    check_eq("t2_wrap", int'(OUT), 0);
    cyc(1, 1, 1, 0, 'h0002, 0);
    cyc(1, 1, 0, 2, 0, 'hFC);
    check_eq("t2_branch", int'(OUT), 'hFFFE);

    // 3: single call/return
    cyc(1, 1, 1, 0, 'h0010, 0);
    cyc(1, 1, 0, 3, 'h0100, 0);
    check_eq("t3_call_out", int'(OUT), 'h0100);
    check_eq("t3_call_depth", int'(depth), 1);
    cyc(1, 1, 0, 4, 0, 0);
    check_eq("t3_ret_out", int'(OUT), 'h0011);

    // 4: overflow on 9th call, LIFO unwind, underflow on 9th return
    cyc(1, 1, 1, 0, 'h0020, 0);
    for (int i = 0; i < 9; i++) cyc(1, 1, 0, 3, 'h1000 + i * 'h10, 0);
    check_eq("t4_ovf", int'(ovf), 1);
    check_eq("t4_full", int'(depth), 8);
    check_eq("t4_hold", int'(OUT), 'h1070);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 4, 0, 0);
    check_eq("t4_unwound", int'(OUT), 'h0021);
    cyc(1, 1, 0, 4, 0, 0);
    check_eq("t4_unf", int'(unf), 1);
    check_eq("t4_unf_hold", int'(OUT), 'h0021);

    // 5: CE low holds everything; load beats RET
    cyc(1, 1, 0, 3, 'h0200, 0);
    cyc(1, 0, 1, 3, 'h0333, 0);
    check_eq("t5_ce_hold", int'(OUT), 'h0200);
    cyc(1, 1, 1, 4, 'h0040, 0);
    check_eq("t5_load", int'(OUT), 'h0040);
    check_eq("t5_depth", int'(depth), 1);

    // 6: reset wins over CALL; jump-to-self then wrap
    cyc(0, 1, 0, 3, 'h0500, 0);
    check_eq("t6_rst_depth", int'(depth), 0);
    check_eq("t6_rst_ovf", int'(ovf), 0);
    cyc(1, 1, 0, 1, 0, 0);
    cyc(1, 1, 0, 1, 0, 0);
    cyc(1, 1, 1, 0, 'hFFFE, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    check_eq("t6_wrap", int'(OUT), 0);

    // Random traffic, biased towards call/return to reach both stack limits
    for (int i = 0; i < 3000; i++) begin
      r_v  = ($urandom_range(0, 99) < 2) ? 0 : 1;
      ce_v = ($urandom_range(0, 99) < 80) ? 1 : 0;
      ld_v = ($urandom_range(0, 99) < 8) ? 1 : 0;
      case ($urandom_range(0, 9))
        0, 1, 2: o = 3;
        3, 4, 5: o = 4;
        default: o = $urandom_range(0, 7);
      endcase
      cyc(r_v[0], ce_v[0], ld_v[0], o, $urandom_range(0, 'hFFFF), $urandom_range(0, 255));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
